subleq_sys: RTL

SUBLEQ_SYS -- requirements
Module: subleq_sys

---
 rtl/subleq_pkg.sv | 25 ++
 rtl/subleq_sys_if.sv | 15 +
 rtl/subleq_ram.sv | 22 ++
 rtl/subleq_sys.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/subleq_pkg.sv
// Shared definitions for the SUBLEQ system: FSM state encoding and the
// reserved HALT/OUT addresses as functions of the address width.
package subleq_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        F_A      = 4'd1,
        F_B      = 4'd2,
        F_C      = 4'd3,
        R_A      = 4'd4,
        R_B      = 4'd5,
        EX       = 4'd6,
        OUT_WAIT = 4'd7,
        HALT     = 4'd8
    } state_t;

    function automatic logic [31:0] halt_addr(input int unsigned aw);
        return (32'd1 << aw) - 32'd1;
    endfunction

    function automatic logic [31:0] out_addr(input int unsigned aw);
        return (32'd1 << aw) - 32'd2;
    endfunction

endpackage

// File: rtl/subleq_sys_if.sv
// Single-port memory bus between the SUBLEQ core and its RAM:
// one synchronous read address/data pair plus one write port.
interface subleq_sys_if #(
    parameter int DW = 8,
    parameter int AW = 8
);
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;

    modport master (output rd_addr, output we, output wa, output wd, input rd_data);
    modport slave  (input rd_addr, input we, input wa, input wd, output rd_data);
endinterface

// File: rtl/subleq_ram.sv
// 2^AW x DW program/data memory with a registered read port; a read of the
// address being written in the same cycle returns the previous word.
module subleq_ram #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input logic         i_clk,
    subleq_sys_if.slave mem
);
    logic [DW-1:0] ram_r [0:(2**AW)-1];
    logic [DW-1:0] rd_data_r;

    // Write port and one-cycle-latency read port; no reset so contents survive it
    always_ff @(posedge i_clk) begin
        if (mem.we) begin
            ram_r[mem.wa] <= mem.wd;
        end
        rd_data_r <= ram_r[mem.rd_addr];
    end

    assign mem.rd_data = rd_data_r;
endmodule

// File: rtl/subleq_sys.sv
// SUBLEQ processor: program-load port, six-cycle fetch/read/execute FSM and,
// when SUBLEQ_SYS_OUT_EN is defined, a valid/ready output port at OUT_ADDR.
module subleq_sys
    import subleq_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_load_en,
    input  logic [AW-1:0] i_load_addr,
    input  logic [DW-1:0] i_load_data,
    input  logic          i_start,
    output logic [DW-1:0] o_out_data,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    output logic          o_halted,
    output logic [AW-1:0] o_pc
);
    localparam logic [AW-1:0] HALT_ADDR = AW'(halt_addr(AW));
    localparam logic [AW-1:0] PC_ONE    = AW'(1);
    localparam logic [AW-1:0] PC_TWO    = AW'(2);
    localparam logic [AW-1:0] PC_STEP   = AW'(3);

    state_t        state_r, state_nx;
    logic [AW-1:0] pc_r, pc_nx;
    logic [AW-1:0] a_r, a_nx, b_r, b_nx, c_r, c_nx;
    logic [DW-1:0] va_r, va_nx;
    logic [DW-1:0] out_data_r, out_data_nx;
    logic          out_valid_r, out_valid_nx;
    logic          halted_r, halted_nx;

    logic [DW-1:0] res_s;
    logic          branch_s;
    logic          is_out_s;
    logic [AW-1:0] rd_addr_s, wr_addr_s;
    logic [DW-1:0] wr_data_s;
    logic          wr_en_s;

    subleq_sys_if #(.DW(DW), .AW(AW)) mem_bus ();

    subleq_ram #(.DW(DW), .AW(AW)) u_ram (
        .i_clk (i_clk),
        .mem   (mem_bus)
    );

    assign mem_bus.rd_addr = rd_addr_s;
    assign mem_bus.we      = wr_en_s;
    assign mem_bus.wa      = wr_addr_s;
    assign mem_bus.wd      = wr_data_s;

    // In EX the read port carries mem[B]; va_r holds mem[A]
    assign res_s    = mem_bus.rd_data - va_r;
    assign branch_s = res_s[DW-1] | (res_s == {DW{1'b0}});

`ifdef SUBLEQ_SYS_OUT_EN
    localparam logic [AW-1:0] OUT_ADDR = AW'(out_addr(AW));
    assign is_out_s = (b_r == OUT_ADDR);
`else
    logic out_ready_unused_s;
    assign is_out_s           = 1'b0;
    assign out_ready_unused_s = i_out_ready;
`endif

    // Next-state, datapath and memory-port control
    always_comb begin
        state_nx     = state_r;
        pc_nx        = pc_r;
        a_nx         = a_r;
        b_nx         = b_r;
        c_nx         = c_r;
        va_nx        = va_r;
        out_data_nx  = out_data_r;
        out_valid_nx = out_valid_r;
        halted_nx    = halted_r;
        rd_addr_s    = pc_r;
        wr_en_s      = 1'b0;
        wr_addr_s    = i_load_addr;
        wr_data_s    = i_load_data;
        case (state_r)
            IDLE, HALT: begin
                if (i_load_en) begin
                    wr_en_s = 1'b1;
                end else if (i_start) begin
                    state_nx  = F_A;
                    pc_nx     = {AW{1'b0}};
                    halted_nx = 1'b0;
                end else begin
                    state_nx = state_r;
                end
            end
            F_A: begin
                rd_addr_s = pc_r;
                state_nx  = F_B;
            end
            F_B: begin
                a_nx      = AW'(mem_bus.rd_data);
                rd_addr_s = pc_r + PC_ONE;
                state_nx  = F_C;
            end
            F_C: begin
                b_nx      = AW'(mem_bus.rd_data);
                rd_addr_s = pc_r + PC_TWO;
                state_nx  = R_A;
            end
            R_A: begin
                c_nx      = AW'(mem_bus.rd_data);
                rd_addr_s = a_r;
                state_nx  = R_B;
            end
            R_B: begin
                va_nx     = mem_bus.rd_data;
                rd_addr_s = b_r;
                state_nx  = EX;
            end
            EX: begin
                if (is_out_s) begin
                    out_data_nx  = va_r;
                    out_valid_nx = 1'b1;
                    state_nx     = OUT_WAIT;
                end else begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = b_r;
                    wr_data_s = res_s;
                    if (branch_s) begin
                        pc_nx = c_r;
                        if (c_r == HALT_ADDR) begin
                            state_nx  = HALT;
                            halted_nx = 1'b1;
                        end else begin
                            state_nx = F_A;
                        end
                    end else begin
                        pc_nx    = pc_r + PC_STEP;
                        state_nx = F_A;
                    end
                end
            end
`ifdef SUBLEQ_SYS_OUT_EN
            OUT_WAIT: begin
                if (i_out_ready) begin
                    out_valid_nx = 1'b0;
                    pc_nx        = pc_r + PC_STEP;
                    state_nx     = F_A;
                end else begin
                    out_valid_nx = 1'b1;
                end
            end
`endif
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_r     <= IDLE;
            pc_r        <= {AW{1'b0}};
            a_r         <= {AW{1'b0}};
            b_r         <= {AW{1'b0}};
            c_r         <= {AW{1'b0}};
            va_r        <= {DW{1'b0}};
            out_data_r  <= {DW{1'b0}};
            out_valid_r <= 1'b0;
            halted_r    <= 1'b0;
        end else begin
            state_r     <= state_nx;
            pc_r        <= pc_nx;
            a_r         <= a_nx;
            b_r         <= b_nx;
            c_r         <= c_nx;
            va_r        <= va_nx;
            out_data_r  <= out_data_nx;
            out_valid_r <= out_valid_nx;
            halted_r    <= halted_nx;
        end
    end

    assign o_pc        = pc_r;
    assign o_halted    = halted_r;
    assign o_out_valid = out_valid_r;
    assign o_out_data  = out_data_r;
endmodule
